ncap_mq_ctrl: RTL and testbench
===============================

// Module: ncap_mq_ctrl
// PURPOSE
//   Multi-queue NIC power-state controller (next generation of the ncap controller).
//   - Counts completed RX/TX packets over NUM_CH AXI-S channels in fixed time windows.
//   - Uses threshold hysteresis, a safeguard counter and host acknowledge to pick HIGH/LOW power.
//   - Raises typed interrupts to the driver.
//   - Sits beside the per-queue datapaths and only snoops handshake signals.
// PARAMETERS
//   NUM_CH  4   number of RX and TX queues snooped (1..16)
//   CNT_W   32  width of window packet counters, snapshots and threshold ports
//   HYST_W  8   width of the hyst_win config port and the quiet-window counter
// PORTS
//   clk             in   1            system clock
//   rst_n           in   1            async reset, active-low
//   interval        in   32           window length in clk cycles; 0 treated as 1
//   thr_high_rx     in   CNT_W        IDLE->HIGH if rx_snap > this
//   thr_high_tx     in   CNT_W        IDLE->HIGH if tx_snap > this
//   thr_low_rx      in   CNT_W        window is "quiet" only if rx_snap < this ...
//   thr_low_tx      in   CNT_W        ... and tx_snap < this
//   thr_safeguard   in   CNT_W        quiet windows tolerated in GOTO_LOW before forced LOW
//   hyst_win        in   HYST_W       consecutive quiet windows needed to leave HIGH; 0 treated as 1
//   aggressive_mode in   1            1: HIGH goes straight to IDLE, skipping GOTO_LOW
//   rx_tvalid       in   NUM_CH       per-queue RX valid
//   rx_tready       in   NUM_CH       per-queue RX ready
//   rx_tlast        in   NUM_CH       per-queue RX last
//   tx_tvalid       in   NUM_CH       per-queue TX valid
//   tx_tready       in   NUM_CH       per-queue TX ready
//   tx_tlast        in   NUM_CH       per-queue TX last
//   irq_ack         in   1            host confirms low-power switch, 1-cycle pulse
//   interrupt       out  1            1-cycle interrupt pulse
//   interrupt_type  out  1            1 = go HIGH, 0 = go LOW; held until the next interrupt
//   state           out  3            one-hot: 001 IDLE, 010 HIGH, 100 GOTO_LOW
//   rx_snap         out  CNT_W        RX packet count of the last completed window
//   tx_snap         out  CNT_W        TX packet count of the last completed window
// BEHAVIOUR
//   Reset values: interrupt=0, interrupt_type=1, state=IDLE, rx_snap=tx_snap=0; all internal counters 0.
//   Packet event: a lane with valid&ready&last in a cycle. Per cycle, popcount of lanes (0..NUM_CH) is added.
//   Accumulators saturate at all-ones and never wrap. Snapshots saturate the same way.
//   Timer:
//     - counts 0..interval-1; win_end is asserted while count == interval-1.
//     - If interval shrinks below the current count, win_end fires on the next cycle.
//   Window rollover (win_end cycle):
//     - snap <= acc + this cycle's popcount (saturating); acc <= 0.
//     - No event is lost or double-counted.
//   eval: registered copy of win_end, 1 cycle later. All FSM decisions happen on eval, using the new snapshots.
//   Thresholds are sampled live at eval.
//   quiet = (rx_snap < thr_low_rx) && (tx_snap < thr_low_tx).
//   IDLE:
//     - on eval, if rx_snap > thr_high_rx or tx_snap > thr_high_tx -> HIGH, interrupt type 1.
//   HIGH:
//     - on eval: quiet -> qcnt++, else qcnt <= 0.
//     - When a quiet eval makes qcnt+1 >= max(hyst_win,1): qcnt <= 0, and
//       - aggressive_mode=1 -> IDLE, interrupt type 0;
//       - aggressive_mode=0 -> GOTO_LOW, interrupt type 0 (request), sg <= 0.
//   GOTO_LOW:
//     - eval & !quiet -> HIGH, interrupt type 1. This has priority over irq_ack in the same cycle.
//     - else irq_ack -> IDLE, no interrupt.
//     - else eval & quiet -> sg++; if sg+1 >= thr_safeguard -> IDLE, interrupt type 0 (forced).
//   irq_ack outside GOTO_LOW is ignored.
//   interrupt is registered and asserts in the cycle after eval, together with the state update.
//   An interrupt is never asserted on two consecutive cycles.
//   rst_n deassertion mid-window restarts the timer at 0, with accumulators cleared.
// TESTING
//   T1: NUM_CH=4, interval=10, thr_high_rx=5; 8 RX pkts in window 1
//       -> rx_snap=8, interrupt type 1 one cycle after eval, state=HIGH.
//   T2: all 4 lanes with last every cycle, CNT_W=4, interval=10
//       -> rx_snap saturates at 15 and does not wrap.
//   T3: HIGH, hyst_win=3, thr_low=2, quiet, quiet, busy, quiet x3
//       -> GOTO_LOW only after the 6th window, interrupt type 0.
//   T4: GOTO_LOW, thr_safeguard=2, no ack, quiet x2
//       -> forced IDLE with interrupt type 0 at the 2nd eval.
//   T5: GOTO_LOW, irq_ack in the same cycle as a busy eval
//       -> state=HIGH, interrupt type 1, ack ignored.
//   T6: aggressive_mode=1, hyst_win=1, one quiet window in HIGH
//       -> IDLE directly, state never 100.
//   T7: assert rst_n low mid-window with acc=3 -> all outputs at reset values.
//       Then release -> first window counts from 0.

Source files
------------

// File: rtl/ncap_mq_ctrl.sv
// Multi-queue NIC power-state controller: counts RX/TX packets per time window
// and drives HIGH/LOW power decisions with hysteresis, safeguard and host ack.
module ncap_mq_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned HYST_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       interval,
  input  logic [CNT_W-1:0]  thr_high_rx,
  input  logic [CNT_W-1:0]  thr_high_tx,
  input  logic [CNT_W-1:0]  thr_low_rx,
  input  logic [CNT_W-1:0]  thr_low_tx,
  input  logic [CNT_W-1:0]  thr_safeguard,
  input  logic [HYST_W-1:0] hyst_win,
  input  logic              aggressive_mode,
  input  logic [NUM_CH-1:0] rx_tvalid,
  input  logic [NUM_CH-1:0] rx_tready,
  input  logic [NUM_CH-1:0] rx_tlast,
  input  logic [NUM_CH-1:0] tx_tvalid,
  input  logic [NUM_CH-1:0] tx_tready,
  input  logic [NUM_CH-1:0] tx_tlast,
  input  logic              irq_ack,
  output logic              interrupt,
  output logic              interrupt_type,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  rx_snap,
  output logic [CNT_W-1:0]  tx_snap
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b001,
    S_HIGH     = 3'b010,
    S_GOTO_LOW = 3'b100
  } state_t;

  localparam int unsigned SW = ((CNT_W > 5) ? CNT_W : 5) + 1;

  state_t             st;
  logic [31:0]        tcnt;
  logic [31:0]        ivl_m1;
  logic               win_end;
  logic               eval;
  logic               act;
  logic [4:0]         rx_pop, tx_pop;
  logic [CNT_W-1:0]   rx_acc, tx_acc;
  logic [CNT_W-1:0]   rx_sum, tx_sum;
  logic [HYST_W-1:0]  qcnt;
  logic [HYST_W-1:0]  hyst_eff;
  logic [CNT_W-1:0]   sg;
  logic               quiet, busy, q_done, sg_done;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [4:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    return (s[SW-1:CNT_W] != '0) ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    rx_pop = '0;
    tx_pop = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rx_pop = rx_pop + 5'(rx_tvalid[i] & rx_tready[i] & rx_tlast[i]);
      tx_pop = tx_pop + 5'(tx_tvalid[i] & tx_tready[i] & tx_tlast[i]);
    end
  end

  assign rx_sum = sat_add(rx_acc, rx_pop);
  assign tx_sum = sat_add(tx_acc, tx_pop);

  // >= rather than == so a shrinking interval closes the window at once
  assign ivl_m1  = (interval == '0) ? '0 : interval - 32'd1;
  assign win_end = (tcnt >= ivl_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      rx_acc  <= '0;
      tx_acc  <= '0;
      rx_snap <= '0;
      tx_snap <= '0;
      eval    <= 1'b0;
    end else begin
      eval <= win_end;
      if (win_end) begin
        tcnt    <= '0;
        rx_snap <= rx_sum;
        tx_snap <= tx_sum;
        rx_acc  <= '0;
        tx_acc  <= '0;
      end else begin
        tcnt   <= tcnt + 32'd1;
        rx_acc <= rx_sum;
        tx_acc <= tx_sum;
      end
    end
  end

  assign quiet    = (rx_snap < thr_low_rx) && (tx_snap < thr_low_tx);
  assign busy     = (rx_snap > thr_high_rx) || (tx_snap > thr_high_tx);
  assign hyst_eff = (hyst_win == '0) ? HYST_W'(1) : hyst_win;
  assign q_done   = (qcnt >= hyst_eff - HYST_W'(1));
  assign sg_done  = (thr_safeguard == '0) || (sg >= thr_safeguard - CNT_W'(1));
  // An eval landing right after an interrupt (interval 1) is skipped so pulses never abut
  assign act      = eval & ~interrupt;
  assign state    = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= S_IDLE;
      interrupt      <= 1'b0;
      interrupt_type <= 1'b1;
      qcnt           <= '0;
      sg             <= '0;
    end else begin
      interrupt <= 1'b0;
      case (st)
        S_IDLE: begin
          if (act && busy) begin
            st             <= S_HIGH;
            interrupt      <= 1'b1;
            interrupt_type <= 1'b1;
          end
        end
        S_HIGH: begin
          if (act) begin
            if (quiet) begin
              if (q_done) begin
                qcnt           <= '0;
                interrupt      <= 1'b1;
                interrupt_type <= 1'b0;
                sg             <= '0;
                st             <= aggressive_mode ? S_IDLE : S_GOTO_LOW;
              end else begin
                qcnt <= qcnt + HYST_W'(1);
              end
            end else begin
              qcnt <= '0;
            end
          end
        end
        S_GOTO_LOW: begin
          if (act && !quiet) begin
            st             <= S_HIGH;
            interrupt      <= 1'b1;
            interrupt_type <= 1'b1;
          end else if (irq_ack) begin
            st <= S_IDLE;
          end else if (act) begin
            if (sg_done) begin
              st             <= S_IDLE;
              interrupt      <= 1'b1;
              interrupt_type <= 1'b0;
            end else begin
              sg <= sg + CNT_W'(1);
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncap_mq_ctrl.sv
// Directed bench for ncap_mq_ctrl: one table row per 10-cycle window plus a
// hand-written mid-window reset sequence.
module tb_ncap_mq_ctrl;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned HW  = 8;
  localparam logic [2:0] ST_I = 3'b001, ST_H = 3'b010, ST_G = 3'b100;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [31:0]    interval;
  logic [CW-1:0]  thr_high_rx, thr_high_tx, thr_low_rx, thr_low_tx, thr_safeguard;
  logic [HW-1:0]  hyst_win;
  logic           aggressive_mode;
  logic [NCH-1:0] rx_tvalid, rx_tready, rx_tlast, tx_tvalid, tx_tready, tx_tlast;
  logic           irq_ack;
  logic           interrupt, interrupt_type;
  logic [2:0]     state;
  logic [CW-1:0]  rx_snap, tx_snap;

  always #5 clk = ~clk;

  ncap_mq_ctrl #(.NUM_CH(NCH), .CNT_W(CW), .HYST_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .interval(interval),
    .thr_high_rx(thr_high_rx), .thr_high_tx(thr_high_tx),
    .thr_low_rx(thr_low_rx), .thr_low_tx(thr_low_tx),
    .thr_safeguard(thr_safeguard), .hyst_win(hyst_win),
    .aggressive_mode(aggressive_mode),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .irq_ack(irq_ack), .interrupt(interrupt), .interrupt_type(interrupt_type),
    .state(state), .rx_snap(rx_snap), .tx_snap(tx_snap)
  );

  typedef struct {
    int         rx, tx;
    logic [3:0] hi, lo, sg;
    logic [7:0] hy;
    logic       ag, ak;
    logic [2:0] e_st;
    logic       e_irq, e_type;
    logic [3:0] e_rx, e_tx;
  } vec_t;

  vec_t v[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(int rx, int tx, int hi, int lo, int sg, int hy,
                              bit ag, bit ak, logic [2:0] es, bit ei, bit et,
                              int erx, int etx);
    vec_t r;
    r.rx = rx; r.tx = tx;
    r.hi = 4'(hi); r.lo = 4'(lo); r.sg = 4'(sg); r.hy = 8'(hy);
    r.ag = ag; r.ak = ak;
    r.e_st = es; r.e_irq = ei; r.e_type = et;
    r.e_rx = 4'(erx); r.e_tx = 4'(etx);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_lanes();
    rx_tvalid = '0; rx_tready = '0; rx_tlast = '0;
    tx_tvalid = '0; tx_tready = '0; tx_tlast = '0;
  endtask

  task automatic check_vec(input vec_t p, input int idx);
    check($sformatf("v%0d state", idx), 32'(state), 32'(p.e_st));
    check($sformatf("v%0d irq", idx), 32'(interrupt), 32'(p.e_irq));
    check($sformatf("v%0d irq_type", idx), 32'(interrupt_type), 32'(p.e_type));
    check($sformatf("v%0d rx_snap", idx), 32'(rx_snap), 32'(p.e_rx));
    check($sformatf("v%0d tx_snap", idx), 32'(tx_snap), 32'(p.e_tx));
  endtask

  // Enters at the negedge of window cycle 0; returns at cycle 0 of the next window.
  task automatic do_window(input vec_t cur, input vec_t prev, input bit chk, input int idx);
    int rr, tr, n;
    rr = cur.rx;
    tr = cur.tx;
    for (int c = 0; c < 10; c++) begin
      idle_lanes();
      irq_ack = 1'b0;
      if (c == 0) begin
        irq_ack = chk ? prev.ak : 1'b0;
        if (chk) check($sformatf("v%0d irq at eval", idx - 1), 32'(interrupt), 32'd0);
      end
      if (c == 1) begin
        if (chk) check_vec(prev, idx - 1);
        thr_high_rx = cur.hi; thr_high_tx = cur.hi;
        thr_low_rx = cur.lo; thr_low_tx = cur.lo;
        thr_safeguard = cur.sg; hyst_win = cur.hy; aggressive_mode = cur.ag;
      end
      if (c == 2 && chk) check($sformatf("v%0d irq width", idx - 1), 32'(interrupt), 32'd0);
      if (c >= 2) begin
        n = (rr > 4) ? 4 : rr;
        rr -= n;
        rx_tvalid = '1; rx_tlast = '1; rx_tready = 4'((32'd1 << n) - 1);
        n = (tr > 4) ? 4 : tr;
        tr -= n;
        tx_tvalid = '1; tx_tready = '1; tx_tlast = 4'((32'd1 << n) - 1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        rx  tx hi lo sg hy ag ak  state irq typ erx etx
    v.push_back(mk( 8, 0, 5, 2, 2, 3, 0, 0, ST_H, 1, 1,  8, 0));
    v.push_back(mk(40, 0, 5, 2, 2, 3, 0, 0, ST_H, 0, 1, 15, 0));
    v.push_back(mk( 0, 0, 5, 2, 2, 3, 0, 0, ST_H, 0, 1,  0, 0));
    v.push_back(mk( 1, 1, 5, 2, 2, 3, 0, 0, ST_H, 0, 1,  1, 1));
    v.push_back(mk( 3, 0, 5, 2, 2, 3, 0, 0, ST_H, 0, 1,  3, 0));
    v.push_back(mk( 0, 0, 5, 2, 2, 3, 0, 0, ST_H, 0, 1,  0, 0));
    v.push_back(mk( 0, 1, 5, 2, 2, 3, 0, 0, ST_H, 0, 1,  0, 1));
    v.push_back(mk( 0, 0, 5, 2, 2, 3, 0, 0, ST_G, 1, 0,  0, 0));
    v.push_back(mk( 0, 0, 5, 2, 2, 3, 0, 0, ST_G, 0, 0,  0, 0));
    v.push_back(mk( 1, 0, 5, 2, 2, 3, 0, 0, ST_I, 1, 0,  1, 0));
    v.push_back(mk( 0, 2, 5, 2, 2, 3, 0, 0, ST_I, 0, 0,  0, 2));
    v.push_back(mk( 5, 0, 5, 2, 2, 3, 0, 0, ST_I, 0, 0,  5, 0));
    v.push_back(mk( 0, 6, 5, 2, 2, 3, 0, 0, ST_H, 1, 1,  0, 6));
    v.push_back(mk( 0, 0, 5, 2, 2, 1, 1, 0, ST_I, 1, 0,  0, 0));
    v.push_back(mk( 6, 0, 5, 2, 2, 0, 0, 0, ST_H, 1, 1,  6, 0));
    v.push_back(mk( 0, 0, 5, 2, 2, 0, 0, 0, ST_G, 1, 0,  0, 0));
    v.push_back(mk( 2, 0, 5, 2, 2, 0, 0, 0, ST_H, 1, 1,  2, 0));
    v.push_back(mk( 0, 0, 5, 2, 2, 1, 0, 0, ST_G, 1, 0,  0, 0));
    v.push_back(mk( 4, 0, 5, 2, 2, 1, 0, 1, ST_H, 1, 1,  4, 0));
    v.push_back(mk( 0, 0, 5, 2, 2, 1, 0, 0, ST_G, 1, 0,  0, 0));
    v.push_back(mk( 0, 0, 5, 2, 5, 1, 0, 1, ST_I, 0, 0,  0, 0));
    v.push_back(mk( 3, 0, 5, 2, 2, 1, 0, 1, ST_I, 0, 0,  3, 0));

    rst_n = 1'b0;
    interval = 32'd10;
    thr_high_rx = 4'd5; thr_high_tx = 4'd5;
    thr_low_rx = 4'd2; thr_low_tx = 4'd2;
    thr_safeguard = 4'd2; hyst_win = 8'd3; aggressive_mode = 1'b0;
    irq_ack = 1'b0;
    idle_lanes();
    repeat (3) @(negedge clk);
    check("reset state", 32'(state), 32'(ST_I));
    check("reset irq", 32'(interrupt), 32'd0);
    check("reset irq_type", 32'(interrupt_type), 32'd1);
    check("reset rx_snap", 32'(rx_snap), 32'd0);
    check("reset tx_snap", 32'(tx_snap), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < v.size(); i++)
      do_window(v[i], v[(i > 0) ? i - 1 : 0], i > 0, i);

    irq_ack = v[v.size() - 1].ak;
    check("last irq at eval", 32'(interrupt), 32'd0);
    @(negedge clk);
    irq_ack = 1'b0;
    check_vec(v[v.size() - 1], v.size() - 1);

    // Mid-window reset with three packets already accumulated
    @(negedge clk);
    for (int c = 2; c < 5; c++) begin
      rx_tvalid = '1; rx_tlast = '1; rx_tready = 4'b0001;
      @(negedge clk);
    end
    idle_lanes();
    rst_n = 1'b0;
    #1;
    check("mid reset state", 32'(state), 32'(ST_I));
    check("mid reset irq", 32'(interrupt), 32'd0);
    check("mid reset irq_type", 32'(interrupt_type), 32'd1);
    check("mid reset rx_snap", 32'(rx_snap), 32'd0);
    check("mid reset tx_snap", 32'(tx_snap), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      idle_lanes();
      if (c == 2 || c == 3) begin
        rx_tvalid = '1; rx_tlast = '1; rx_tready = 4'b0010;
      end
      if (c == 9) check("post reset snap before boundary", 32'(rx_snap), 32'd0);
      @(negedge clk);
    end
    check("post reset rx_snap", 32'(rx_snap), 32'd2);
    @(negedge clk);
    check("post reset state", 32'(state), 32'(ST_I));
    check("post reset irq", 32'(interrupt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
